// File: rtl/isa_dispatch_pkg.sv
// isa_dispatch_pkg: shared types and field positions for the dispatcher.
package isa_dispatch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    // Program entry layout is {core_mask, wait, command}; the command sits at the bottom.
    localparam int CMD_LSB = 0;

    function automatic int wait_bit_of(input int cmd_w);
        return CMD_LSB + cmd_w;
    endfunction

    function automatic int mask_lsb_of(input int cmd_w);
        return CMD_LSB + cmd_w + 1;
    endfunction

    // Status word layout: {cycle_count[29:0], error, done_all}.
    localparam int STAT_DONE_BIT = 0;
    localparam int STAT_ERR_BIT  = 1;
    localparam int STAT_CNT_LSB  = 2;
    localparam int STAT_CNT_W    = 30;

endpackage

// File: rtl/isa_prog_ram.sv
// isa_prog_ram: simple dual-port program store, one write port, one registered read port.
module isa_prog_ram #(
    parameter int WIDTH = 45,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: no reset so the array maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: registered output, one cycle of latency.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/isa_dispatch_ctrl.sv
// isa_dispatch_ctrl: host-loaded program buffer that issues commands to a set of cores
// and waits on their done pulses where an entry asks for it.
// Optional feature: define ISA_DISPATCH_TIMEOUT_EN to add a WAIT watchdog (TIMEOUT_CYC).
module isa_dispatch_ctrl
    import isa_dispatch_pkg::*;
#(
    parameter int  CMD_W       = 42,
    parameter int  NUM_CORES   = 2,
    parameter int  INS_DEPTH   = 16,
    parameter int  CNT_W       = 31,
    parameter int  TIMEOUT_CYC = 1 << 20,
    localparam int AW          = $clog2(INS_DEPTH),
    localparam int ENTRY_W     = NUM_CORES + 1 + CMD_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 soft_rst,
    input  logic                 start,
    input  logic                 prog_we,
    input  logic [AW-1:0]        prog_addr,
    input  logic [ENTRY_W-1:0]   prog_data,
    output logic [CMD_W-1:0]     command_out,
    output logic [NUM_CORES-1:0] command_we,
    input  logic [NUM_CORES-1:0] core_done,
    output logic                 busy,
    output logic                 done_all,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [31:0]          status
);

    localparam int WAIT_BIT = wait_bit_of(CMD_W);
    localparam int MASK_LSB = mask_lsb_of(CMD_W);

    state_t                 state_reg, state_next;
    logic [AW-1:0]          pc_reg, pc_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic                   err_reg, err_next;
    logic [NUM_CORES-1:0]   pending_reg, pending_next;
    logic [NUM_CORES-1:0]   seen_reg, seen_next;
    logic [CMD_W-1:0]       cmd_reg, cmd_next;
    logic [NUM_CORES-1:0]   we_reg, we_next;
    logic [31:0]            status_reg, status_next;

    logic [ENTRY_W-1:0]     rd_entry;
    logic [CMD_W-1:0]       rd_cmd;
    logic                   rd_wait;
    logic [NUM_CORES-1:0]   rd_mask;
    logic [NUM_CORES-1:0]   seen_upd;
    logic                   last_entry;
    logic                   ram_we;

`ifdef ISA_DISPATCH_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
    logic [WD_W-1:0] wd_reg, wd_next;
`else
    logic [31:0] timeout_unused;
    assign timeout_unused = 32'(TIMEOUT_CYC);
`endif

    assign rd_cmd     = rd_entry[CMD_LSB +: CMD_W];
    assign rd_wait    = rd_entry[WAIT_BIT];
    assign rd_mask    = rd_entry[MASK_LSB +: NUM_CORES];
    assign seen_upd   = seen_reg | (core_done & pending_reg);
    assign last_entry = (pc_reg == AW'(INS_DEPTH - 1));
    assign busy       = (state_reg == ST_FETCH) || (state_reg == ST_ISSUE) || (state_reg == ST_WAIT);
    assign done_all   = (state_reg == ST_DONE);
    // Writes while running are dropped (and flagged as an error below).
    assign ram_we     = prog_we && !busy && !soft_rst;

    isa_prog_ram #(
        .WIDTH (ENTRY_W),
        .DEPTH (INS_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (state_reg == ST_FETCH),
        .raddr (pc_reg),
        .rdata (rd_entry)
    );

    // Next-state and datapath updates; soft_rst overrides everything at the end.
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        cnt_next     = cnt_reg;
        err_next     = err_reg;
        pending_next = pending_reg;
        seen_next    = seen_reg;
        cmd_next     = cmd_reg;
        we_next      = '0;
`ifdef ISA_DISPATCH_TIMEOUT_EN
        wd_next      = wd_reg;
`endif

        if (busy && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + 1'b1;
        end
        if (prog_we && busy) begin
            err_next = 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (start) begin
                    err_next   = 1'b0;
                    pc_next    = '0;
                    state_next = ST_FETCH;
                end
                if (|core_done) begin
                    err_next = 1'b1;
                end
            end
            ST_FETCH: begin
                state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (rd_mask == '0) begin
                    state_next = ST_DONE;
                end else begin
                    cmd_next     = rd_cmd;
                    we_next      = rd_mask;
                    seen_next    = '0;
                    pending_next = rd_mask;
                    if (rd_wait) begin
                        state_next = ST_WAIT;
`ifdef ISA_DISPATCH_TIMEOUT_EN
                        wd_next    = WD_W'(TIMEOUT_CYC - 1);
`endif
                    end else if (last_entry) begin
                        state_next = ST_DONE;
                    end else begin
                        pc_next    = pc_reg + 1'b1;
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_WAIT: begin
                seen_next = seen_upd;
                if (seen_upd == pending_reg) begin
                    if (last_entry) begin
                        state_next = ST_DONE;
                    end else begin
                        pc_next    = pc_reg + 1'b1;
                        state_next = ST_FETCH;
                    end
`ifdef ISA_DISPATCH_TIMEOUT_EN
                end else if (wd_reg == '0) begin
                    err_next   = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    wd_next = wd_reg - 1'b1;
`endif
                end
            end
            ST_DONE: begin
                if (!start) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        status_next                                 = '0;
        status_next[STAT_DONE_BIT]                  = done_all;
        status_next[STAT_ERR_BIT]                   = err_reg;
        status_next[STAT_CNT_LSB +: STAT_CNT_W]     = cnt_reg[STAT_CNT_W-1:0];

        if (soft_rst) begin
            state_next   = ST_IDLE;
            pc_next      = '0;
            cnt_next     = '0;
            err_next     = 1'b0;
            pending_next = '0;
            seen_next    = '0;
            cmd_next     = '0;
            we_next      = '0;
            status_next  = '0;
`ifdef ISA_DISPATCH_TIMEOUT_EN
            wd_next      = '0;
`endif
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            pc_reg      <= '0;
            cnt_reg     <= '0;
            err_reg     <= 1'b0;
            pending_reg <= '0;
            seen_reg    <= '0;
            cmd_reg     <= '0;
            we_reg      <= '0;
            status_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            cnt_reg     <= cnt_next;
            err_reg     <= err_next;
            pending_reg <= pending_next;
            seen_reg    <= seen_next;
            cmd_reg     <= cmd_next;
            we_reg      <= we_next;
            status_reg  <= status_next;
        end
    end

`ifdef ISA_DISPATCH_TIMEOUT_EN
    // Watchdog down-counter, reloaded when an entry enters WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_reg <= '0;
        end else begin
            wd_reg <= wd_next;
        end
    end
`endif

    assign command_out = cmd_reg;
    assign command_we  = we_reg;
    assign cycle_count = cnt_reg;
    assign status      = status_reg;

endmodule

// File: tb/tb_isa_dispatch_ctrl.sv
// tb_isa_dispatch_ctrl: randomized program runs against a program-level reference model.
// Honors ISA_DISPATCH_TIMEOUT_EN to exercise the watchdog (TIMEOUT_CYC=8).
module tb_isa_dispatch_ctrl;

    localparam int CW    = 42;
    localparam int NC    = 2;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int TO    = 8;

    typedef struct { logic [NC-1:0] mask; logic wt; logic [CW-1:0] cmd; } entry_t;
    typedef struct { logic [NC-1:0] mask; logic [CW-1:0] cmd; int at; } issue_t;
    typedef struct { int at; int cnt; bit err; } done_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              soft_rst = 1'b0;
    logic              start = 1'b0;
    logic              prog_we = 1'b0;
    logic [AW-1:0]     prog_addr = '0;
    logic [NC+CW:0]    prog_data = '0;
    logic [CW-1:0]     command_out;
    logic [NC-1:0]     command_we;
    logic [NC-1:0]     core_done;
    logic              busy;
    logic              done_all;
    logic [30:0]       cycle_count;
    logic [31:0]       status;

    logic [NC-1:0]     resp_done = '0;
    logic [NC-1:0]     man_done = '0;
    bit                resp_en = 1'b0;
    int                resp_delay [NC];
    int                cd [NC];

    entry_t            model_mem [DEPTH];
    issue_t            issue_q [$];
    done_t             done_q [$];
    int                cyc = 0;
    int                start_edge = 0;
    int                nstrobe = 0;
    int                checks = 0;
    int                passes = 0;
    bit                prev_done = 1'b0;
    bit                status_pend = 1'b0;
    logic [31:0]       status_exp = '0;

    assign core_done = resp_done | man_done;

    isa_dispatch_ctrl #(
        .CMD_W       (CW),
        .NUM_CORES   (NC),
        .INS_DEPTH   (DEPTH),
        .CNT_W       (31),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .soft_rst    (soft_rst),
        .start       (start),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .command_out (command_out),
        .command_we  (command_we),
        .core_done   (core_done),
        .busy        (busy),
        .done_all    (done_all),
        .cycle_count (cycle_count),
        .status      (status)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic logic [CW-1:0] rand_cmd();
        return CW'({$urandom(), $urandom()});
    endfunction

    // Core model: each strobed core answers with one done pulse resp_delay cycles later.
    always @(posedge clk) begin
        #1;
        for (int c = 0; c < NC; c++) begin
            resp_done[c] = 1'b0;
            if (cd[c] > 0) begin
                cd[c]--;
                if (cd[c] == 0) resp_done[c] = 1'b1;
            end
            if (resp_en && command_we[c]) begin
                cd[c]        = resp_delay[c];
                resp_done[c] = (resp_delay[c] == 0);
            end
        end
    end

    // Monitor: pops expected issues / completions whenever the DUT presents one.
    always @(negedge clk) begin
        issue_t it;
        done_t  dt;
        if (rst_n) begin
            if (command_we != '0) begin
                nstrobe++;
                if (issue_q.size() == 0) begin
                    chk("spurious_issue", 64'(command_we), 64'(0));
                end else begin
                    it = issue_q.pop_front();
                    $display("issue mask=%b cmd=0x%0h cycle=%0d", command_we, command_out, cyc);
                    chk("issue_mask", 64'(command_we), 64'(it.mask));
                    chk("issue_cmd", 64'(command_out), 64'(it.cmd));
                    chk("issue_cycle", 64'(cyc), 64'(it.at));
                end
            end
            if (status_pend) begin
                chk("status_word", 64'(status), 64'(status_exp));
                status_pend = 1'b0;
            end
            if (done_all && !prev_done) begin
                if (done_q.size() == 0) begin
                    chk("spurious_done", 64'(done_all), 64'(0));
                end else begin
                    dt = done_q.pop_front();
                    $display("done count=%0d cycle=%0d", cycle_count, cyc);
                    chk("done_cycle", 64'(cyc), 64'(dt.at));
                    chk("done_count", 64'(cycle_count), 64'(dt.cnt));
                    status_exp  = {dt.cnt[29:0], dt.err, 1'b1};
                    status_pend = 1'b1;
                end
            end
        end
        prev_done = done_all;
    end

    // Reference model: walk the program and derive issue times and final count.
    task automatic expect_run(input bit no_resp, input bit err_exp);
        int off;
        int w;
        issue_t it;
        done_t dt;
        off = 2;
        for (int pc = 0; pc < DEPTH; pc++) begin
            if (model_mem[pc].mask == '0) begin
                dt.at = start_edge + off; dt.cnt = off; dt.err = err_exp;
                done_q.push_back(dt);
                return;
            end
            it.mask = model_mem[pc].mask; it.cmd = model_mem[pc].cmd; it.at = start_edge + off;
            issue_q.push_back(it);
            if (model_mem[pc].wt) begin
                if (no_resp) begin
`ifdef ISA_DISPATCH_TIMEOUT_EN
                    dt.at = start_edge + off + TO; dt.cnt = off + TO; dt.err = 1'b1;
                    done_q.push_back(dt);
`endif
                    return;
                end
                w = 0;
                for (int c = 0; c < NC; c++)
                    if (model_mem[pc].mask[c] && (resp_delay[c] + 1 > w)) w = resp_delay[c] + 1;
                off += w;
            end
            if (pc == DEPTH - 1) begin
                dt.at = start_edge + off; dt.cnt = off; dt.err = err_exp;
                done_q.push_back(dt);
                return;
            end
            off += 2;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [NC-1:0] m, input logic w, input logic [CW-1:0] c);
        prog_we   = 1'b1;
        prog_addr = AW'(a);
        prog_data = {m, w, c};
        model_mem[a].mask = m; model_mem[a].wt = w; model_mem[a].cmd = c;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic launch(input bit no_resp, input bit err_exp);
        start      = 1'b1;
        start_edge = cyc + 1;
        nstrobe    = 0;
        expect_run(no_resp, err_exp);
        tick();
    endtask

    task automatic wait_strobe();
        for (int i = 0; i < 20 && command_we == '0; i++) tick();
        chk("strobe_seen", 64'(command_we != '0), 64'(1));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400 && !done_all; i++) tick();
        chk("done_reached", 64'(done_all), 64'(1));
    endtask

    // Holding start in DONE must not relaunch; dropping it returns to IDLE.
    task automatic finish_run();
        repeat (8) tick();
        chk("done_hold", 64'(done_all), 64'(1));
        start = 1'b0;
        tick(); tick();
        chk("back_idle", 64'({busy, done_all}), 64'(0));
        chk("queue_drained", 64'(issue_q.size() + done_q.size()), 64'(0));
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_cmd"}, 64'(command_out), 64'(0));
        chk({tag, "_we"}, 64'(command_we), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done_all), 64'(0));
        chk({tag, "_count"}, 64'(cycle_count), 64'(0));
        chk({tag, "_status"}, 64'(status), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int len;
        logic [CW-1:0] c1;
        for (int c = 0; c < NC; c++) begin resp_delay[c] = 0; cd[c] = 0; end
        for (int a = 0; a < DEPTH; a++) begin
            model_mem[a].mask = '0; model_mem[a].wt = 1'b0; model_mem[a].cmd = '0;
        end

        // Reset state.
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check_cleared("reset");

        // Non-wait issue; entry 0 written in the same cycle start is sampled.
        resp_en = 1'b1;
        for (int c = 0; c < NC; c++) resp_delay[c] = $urandom_range(0, 5);
        load(1, 2'b10, 1'b0, 42'h6);
        load(2, 2'b00, 1'b0, 42'h0);
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = {2'b01, 1'b0, 42'h5};
        model_mem[0].mask = 2'b01; model_mem[0].wt = 1'b0; model_mem[0].cmd = 42'h5;
        launch(1'b0, 1'b0);
        prog_we = 1'b0;
        wait_done();
        finish_run();

        // Wait on two cores: done[0] at +3 and again at +5, done[1] at +7.
        resp_en = 1'b0;
        resp_delay[0] = 3; resp_delay[1] = 7;
        load(0, 2'b11, 1'b1, 42'hA);
        load(1, 2'b00, 1'b0, 42'h0);
        launch(1'b0, 1'b0);
        wait_strobe();
        for (int i = 0; i < 9; i++) begin
            man_done = ((i == 3 || i == 5) ? 2'b01 : 2'b00) | ((i == 7) ? 2'b10 : 2'b00);
            if (i == 7) chk("wait_held", 64'({busy, done_all}), 64'(2'b10));
            tick();
        end
        man_done = '0;
        wait_done();
        finish_run();

        // Full program of 16 non-wait entries: no terminator, no pc wrap.
        resp_en = 1'b1;
        for (int a = 0; a < DEPTH; a++) load(a, NC'($urandom_range(1, 3)), 1'b0, rand_cmd());
        launch(1'b0, 1'b0);
        wait_done();
        finish_run();
        chk("strobe_count", 64'(nstrobe), 64'(16));

        // prog_we during WAIT: flagged and dropped; rerun shows original command.
        resp_delay[0] = 4;
        c1 = rand_cmd();
        load(0, 2'b01, 1'b1, c1);
        load(1, 2'b00, 1'b0, 42'h0);
        launch(1'b0, 1'b1);
        wait_strobe();
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = {2'b10, 1'b0, ~c1};
        tick();
        prog_we = 1'b0;
        wait_done();
        finish_run();
        launch(1'b0, 1'b0);
        wait_done();
        finish_run();

        // Randomized programs.
        for (int r = 0; r < 5; r++) begin
            len = $urandom_range(1, DEPTH);
            for (int c = 0; c < NC; c++) resp_delay[c] = $urandom_range(0, 5);
            for (int a = 0; a < len; a++)
                load(a, NC'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), rand_cmd());
            if (len < DEPTH) load(len, 2'b00, 1'b0, rand_cmd());
            launch(1'b0, 1'b0);
            wait_done();
            finish_run();
        end

        // No responses: block sits in WAIT until soft_rst clears it.
        resp_en = 1'b0;
        c1 = rand_cmd();
        load(0, 2'b11, 1'b1, c1);
        load(1, 2'b00, 1'b0, 42'h0);
        launch(1'b1, 1'b0);
        wait_strobe();
`ifdef ISA_DISPATCH_TIMEOUT_EN
        repeat (3) tick();
`else
        repeat (30) tick();
`endif
        chk("wait_stuck", 64'({busy, done_all}), 64'(2'b10));
        soft_rst = 1'b1; start = 1'b0;
        tick();
        soft_rst = 1'b0;
        issue_q.delete(); done_q.delete();
        check_cleared("soft_rst");

        // Program retained across soft_rst.
        resp_en = 1'b1;
        for (int c = 0; c < NC; c++) resp_delay[c] = $urandom_range(0, 5);
        launch(1'b0, 1'b0);
        wait_done();
        finish_run();

        // Asynchronous reset mid-WAIT clears immediately.
        resp_en = 1'b0;
        launch(1'b1, 1'b0);
        wait_strobe();
        tick();
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check_cleared("async_rst");
        issue_q.delete(); done_q.delete();
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check_cleared("post_rst");

`ifdef ISA_DISPATCH_TIMEOUT_EN
        // Watchdog: no done pulses, expect error + DONE after TO WAIT cycles.
        load(0, 2'b01, 1'b1, rand_cmd());
        load(1, 2'b00, 1'b0, 42'h0);
        launch(1'b1, 1'b0);
        wait_done();
        finish_run();
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
